// File: rtl/param_updown_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_updown_counter_if: control/status bundle for the counter.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_data;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             tc_pulse;
  logic             halted;

  modport master (
    output clr, ld, ld_data, en, dir, mode,
    input  Q, tc, tc_pulse, halted
  );

  modport slave (
    input  clr, ld, ld_data, en, dir, mode,
    output Q, tc, tc_pulse, halted
  );
endinterface
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_updown_counter: loadable up/down counter with wrap, saturate, |
// | one-shot and auto-reload terminal behaviour.  Rev 1.0               |
// +--------------------------------------------------------------------+
module param_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_updown_counter_if.slave bus
);

  localparam logic [1:0] c_mode_wrap   = 2'b00;
  localparam logic [1:0] c_mode_sat    = 2'b01;
  localparam logic [1:0] c_mode_oneshot = 2'b10;
  localparam logic [1:0] c_mode_reload = 2'b11;

  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_halt = 1'b1;

  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc_pulse;
  logic [0:0]       r_state;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_pulse_nxt;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_terminal;
  logic             w_tc;
  logic             w_step;
  logic             w_moved;

  assign w_terminal = bus.dir ? c_all_ones : c_zero;
  assign w_tc       = (r_q == w_terminal);
  assign w_step     = bus.en && (r_state == c_st_run);

  always_comb begin
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_state_nxt  = r_state;
    w_pulse_nxt  = 1'b0;
    w_moved      = 1'b0;
    if (bus.clr) begin
      w_q_nxt     = c_zero;
      w_state_nxt = c_st_run;
    end else if (bus.ld) begin
      w_q_nxt      = bus.ld_data;
      w_reload_nxt = bus.ld_data;
      w_state_nxt  = c_st_run;
    end else if (w_step) begin
      if (!w_tc) begin
        w_q_nxt = bus.dir ? (r_q + c_one) : (r_q - c_one);
        w_moved = 1'b1;
      end else begin
        case (bus.mode)
          c_mode_wrap: begin
            w_q_nxt = bus.dir ? c_zero : c_all_ones;
            w_moved = 1'b1;
          end
          c_mode_sat: begin
            w_q_nxt = r_q;
          end
          c_mode_oneshot: begin
            w_state_nxt = c_st_halt;
          end
          c_mode_reload: begin
            w_q_nxt = r_reload;
            w_moved = 1'b1;
          end
          default: begin
            w_q_nxt = r_q;
          end
        endcase
      end
      // Holding at terminal (saturate/one-shot) must not re-pulse.
      w_pulse_nxt = w_moved && (w_q_nxt == w_terminal);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= RESET_VAL;
      r_reload   <= RESET_VAL;
      r_tc_pulse <= 1'b0;
      r_state    <= c_st_run;
    end else begin
      r_q        <= w_q_nxt;
      r_reload   <= w_reload_nxt;
      r_tc_pulse <= w_pulse_nxt;
      r_state    <= w_state_nxt;
    end
  end

  assign bus.Q        = r_q;
  assign bus.tc       = w_tc;
  assign bus.tc_pulse = r_tc_pulse;
  assign bus.halted   = (r_state == c_st_halt);

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_param_updown_counter: directed vector bench for the counter.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_param_updown_counter;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] ld_data;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] q;
    logic       tc;
    logic       pulse;
    logic       halted;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  param_updown_counter_if #(.WIDTH(8)) bus ();

  param_updown_counter #(
    .WIDTH    (8),
    .RESET_VAL(8'd0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic l, input logic [7:0] d,
                              input logic e, input logic dr, input logic [1:0] m,
                              input logic [7:0] q, input logic tc, input logic p,
                              input logic h);
    vec_t v;
    v.clr = c; v.ld = l; v.ld_data = d; v.en = e; v.dir = dr; v.mode = m;
    v.q = q; v.tc = tc; v.pulse = p; v.halted = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    bus.clr = v.clr; bus.ld = v.ld; bus.ld_data = v.ld_data;
    bus.en = v.en; bus.dir = v.dir; bus.mode = v.mode;
    @(posedge clk);
    #1;
    chk({name, ".Q"},        32'(bus.Q),        32'(v.q));
    chk({name, ".tc"},       32'(bus.tc),       32'(v.tc));
    chk({name, ".tc_pulse"}, 32'(bus.tc_pulse), 32'(v.pulse));
    chk({name, ".halted"},   32'(bus.halted),   32'(v.halted));
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    chk({name, ".Q"},        32'(bus.Q),        32'd0);
    chk({name, ".tc_pulse"}, 32'(bus.tc_pulse), 32'd0);
    chk({name, ".halted"},   32'(bus.halted),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.ld = 1'b0; bus.ld_data = 8'd0;
    bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.Q", 32'(bus.Q), 32'd0);
    chk("rst.tc", 32'(bus.tc), 32'd1);
    chk("rst.tc_pulse", 32'(bus.tc_pulse), 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(mk(0,1,40,0,0,0, 40,0,0,0), "ar0_ld");
    apply(mk(0,0,0,1,0,0, 39,0,0,0), "ar0_step");
    async_reset("ar_midcount");
    apply(mk(0,1,1,0,0,2, 1,0,0,0), "ar1_ld");
    apply(mk(0,0,0,1,0,2, 0,1,1,0), "ar1_term");
    async_reset("ar_pulse");
    apply(mk(0,1,1,0,0,2, 1,0,0,0), "ar2_ld");
    apply(mk(0,0,0,1,0,2, 0,1,1,0), "ar2_term");
    apply(mk(0,0,0,1,0,2, 0,1,0,1), "ar2_halt");
    async_reset("ar_halted");

    // One-shot count down from 5, then sit halted.
    tbl.push_back(mk(0,1,5,1,0,2, 5,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 4,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 3,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 2,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,2, 0,1,0,1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,1,0,2, 0,1,0,1));
    tbl.push_back(mk(0,1,4,1,0,2, 4,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 3,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,2, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,2, 0,1,0,1));
    // Wrap down and up.
    tbl.push_back(mk(0,1,2,0,0,0, 2,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,0, 255,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 254,0,0,0));
    tbl.push_back(mk(0,1,254,0,1,0, 254,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0, 255,1,1,0));
    tbl.push_back(mk(0,0,0,1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0, 1,0,0,0));
    // Saturate up.
    tbl.push_back(mk(0,1,253,0,1,1, 253,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,1, 254,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,1, 255,1,1,0));
    tbl.push_back(mk(0,0,0,1,1,1, 255,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,1, 255,1,0,0));
    // Auto-reload down from 3.
    tbl.push_back(mk(0,1,3,0,0,3, 3,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 2,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,3, 3,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 2,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,3, 3,0,0,0));
    // Reload value equal to terminal pulses on every reload.
    tbl.push_back(mk(0,1,0,0,0,3, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,3, 0,1,1,0));
    // clr leaves the reload register intact.
    tbl.push_back(mk(0,1,2,0,0,3, 2,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,3, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,3, 2,0,0,0));
    // Priority clr > ld > step.
    tbl.push_back(mk(0,1,7,0,0,0, 7,0,0,0));
    tbl.push_back(mk(1,1,9,1,0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,9,1,0,0, 9,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 8,0,0,0));
    // Direction toggling and enable hold.
    tbl.push_back(mk(0,1,10,0,0,0, 10,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 9,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0, 10,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0, 11,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 10,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0, 10,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0));
    // tc follows dir combinationally.
    tbl.push_back(mk(0,1,255,0,0,0, 255,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 255,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
